// File: rtl/fpu_bus_if.sv
// Byte-wide chip-select/strobe register interface between the host CPU and the FPU core.
// Assembles operands and opcode, issues a one-cycle start, latches the result and holds cmd_end until acknowledged.
module fpu_bus_if #(
   parameter int OP_W = 4
) (
   input  logic            clk,
   input  logic            arst,
   input  logic [7:0]      databus_in,
   output logic [7:0]      databus_out,
   input  logic [3:0]      addr,
   input  logic            cs,
   input  logic            rd,
   input  logic            wr,
   input  logic            end_ack,
   output logic            cmd_end,
   output logic            busy,
   output logic [31:0]     operand_a,
   output logic [31:0]     operand_b,
   output logic [OP_W-1:0] operation,
   output logic            start,
   input  logic            core_done,
   input  logic [31:0]     core_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        wr_q;
   logic        write_event;
   logic        start_accept;
   logic [31:0] result;

   // A write is the falling edge of wr as seen on the clock, so a long strobe writes once.
   assign write_event  = !cs && !wr && wr_q;
   assign start_accept = write_event && (addr == 4'h9) && (state == IDLE);

   assign busy    = (state == RUN);
   assign cmd_end = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: next state defaults to the current state first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_accept) state_next = RUN;
         RUN:     if (core_done)    state_next = DONE;
         DONE:    if (end_ack)      state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_q      <= 1'b1;
         start     <= 1'b0;
         operand_a <= '0;
         operand_b <= '0;
         operation <= '0;
         result    <= '0;
      end else begin
         wr_q  <= wr;
         start <= start_accept;
         // Operands are frozen while the core is running.
         if (write_event && (state != RUN)) begin
            case (addr)
               4'h0:    operand_a[7:0]   <= databus_in;
               4'h1:    operand_a[15:8]  <= databus_in;
               4'h2:    operand_a[23:16] <= databus_in;
               4'h3:    operand_a[31:24] <= databus_in;
               4'h4:    operand_b[7:0]   <= databus_in;
               4'h5:    operand_b[15:8]  <= databus_in;
               4'h6:    operand_b[23:16] <= databus_in;
               4'h7:    operand_b[31:24] <= databus_in;
               4'h8:    operation        <= databus_in[OP_W-1:0];
               default: ;
            endcase
         end
         if ((state == RUN) && core_done) begin
            result <= core_result;
         end
      end
   end

   always_comb begin
      databus_out = 8'h00;
      if (!cs && !rd) begin
         case (addr)
            4'h0:    databus_out = operand_a[7:0];
            4'h1:    databus_out = operand_a[15:8];
            4'h2:    databus_out = operand_a[23:16];
            4'h3:    databus_out = operand_a[31:24];
            4'h4:    databus_out = operand_b[7:0];
            4'h5:    databus_out = operand_b[15:8];
            4'h6:    databus_out = operand_b[23:16];
            4'h7:    databus_out = operand_b[31:24];
            4'h8:    databus_out = 8'(operation);
            4'h9:    databus_out = result[7:0];
            4'hA:    databus_out = result[15:8];
            4'hB:    databus_out = result[23:16];
            4'hC:    databus_out = result[31:24];
            default: databus_out = 8'h00;
         endcase
      end
   end

endmodule
